// File: rtl/otter_mem_pkg.sv
// rtl/otter_mem_pkg.sv - shared types for the OTTER data-memory port
package otter_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [31:0] IO_BASE = 32'h1100_0000;

  // size stays a raw 2-bit field so the illegal encoding 3 can be carried and rejected
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        sign;
  } mem_req_t;

endpackage

// File: rtl/otter_dmem_arbiter_if.sv
// rtl/otter_dmem_arbiter_if.sv - requester and memory port-2 signal bundle
interface otter_dmem_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              M0_REQ,   M1_REQ;
  logic              M0_WE,    M1_WE;
  logic [ADDR_W-1:0] M0_ADDR,  M1_ADDR;
  logic [31:0]       M0_DIN,   M1_DIN;
  logic [1:0]        M0_SIZE,  M1_SIZE;
  logic              M0_SIGN,  M1_SIGN;
  logic              M0_GNT,   M1_GNT;
  logic              M0_RESP,  M1_RESP;
  logic              M0_ERR,   M1_ERR;
  logic [31:0]       M0_RDATA, M1_RDATA;

  logic [ADDR_W-1:0] MEM_ADDR2;
  logic [31:0]       MEM_DIN2;
  logic              MEM_WRITE2;
  logic              MEM_READ2;
  logic [1:0]        MEM_SIZE;
  logic              MEM_SIGN;
  logic [31:0]       MEM_DOUT2;

  modport slave (
    input  M0_REQ, M1_REQ, M0_WE, M1_WE, M0_ADDR, M1_ADDR,
           M0_DIN, M1_DIN, M0_SIZE, M1_SIZE, M0_SIGN, M1_SIGN,
           MEM_DOUT2,
    output M0_GNT, M1_GNT, M0_RESP, M1_RESP, M0_ERR, M1_ERR,
           M0_RDATA, M1_RDATA,
           MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
  );

  modport master (
    output M0_REQ, M1_REQ, M0_WE, M1_WE, M0_ADDR, M1_ADDR,
           M0_DIN, M1_DIN, M0_SIZE, M1_SIZE, M0_SIGN, M1_SIGN,
           MEM_DOUT2,
    input  M0_GNT, M1_GNT, M0_RESP, M1_RESP, M0_ERR, M1_ERR,
           M0_RDATA, M1_RDATA,
           MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
  );

endinterface

// File: rtl/otter_dmem_align_chk.sv
// rtl/otter_dmem_align_chk.sv - flags accesses the memory cannot perform in one word
module otter_dmem_align_chk
  import otter_mem_pkg::*;
(
  input  mem_req_t i_req,
  output logic     o_err
);

  logic w_unused;

  assign w_unused = ^{i_req.we, i_req.addr[31:2], i_req.din, i_req.sign};

  always_comb begin
    o_err = 1'b0;
    case (i_req.size)
      SZ_BYTE: o_err = 1'b0;
      SZ_HALF: o_err = i_req.addr[0];
      SZ_WORD: o_err = |i_req.addr[1:0];
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/otter_dmem_arbiter.sv
// rtl/otter_dmem_arbiter.sv - two-master arbiter for OTTER memory port 2
// One access per cycle; a one-stage response pipeline routes load data back to its issuer.
module otter_dmem_arbiter
  import otter_mem_pkg::*;
#(
  parameter bit RR_EN  = 1'b1,
  parameter int ADDR_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  otter_dmem_arbiter_if.slave  bus
);

  mem_req_t w_req0;
  mem_req_t w_req1;
  mem_req_t w_sel;
  mem_req_t w_out;
  mem_req_t r_hold;

  logic w_gnt0;
  logic w_gnt1;
  logic w_any;
  logic w_err;
  logic w_m0_wins;
  logic w_unused;

  logic r_last;
  logic r_valid;
  logic r_owner;
  logic r_is_read;
  logic r_err;

  always_comb begin
    w_req0      = '0;
    w_req0.we   = bus.M0_WE;
    w_req0.addr = 32'(bus.M0_ADDR);
    w_req0.din  = bus.M0_DIN;
    w_req0.size = bus.M0_SIZE;
    w_req0.sign = bus.M0_SIGN;

    w_req1      = '0;
    w_req1.we   = bus.M1_WE;
    w_req1.addr = 32'(bus.M1_ADDR);
    w_req1.din  = bus.M1_DIN;
    w_req1.size = bus.M1_SIZE;
    w_req1.sign = bus.M1_SIGN;
  end

  // r_last = 1 means M1 was granted most recently, so M0 wins the next contention
  assign w_m0_wins = RR_EN ? r_last : 1'b1;
  assign w_gnt0    = RST_N & bus.M0_REQ & (~bus.M1_REQ | w_m0_wins);
  assign w_gnt1    = RST_N & bus.M1_REQ & ~w_gnt0;
  assign w_any     = w_gnt0 | w_gnt1;
  assign w_sel     = w_gnt1 ? w_req1 : w_req0;

  otter_dmem_align_chk u_align_chk (
    .i_req (w_sel),
    .o_err (w_err)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_last    <= 1'b1;
      r_hold    <= '0;
      r_valid   <= 1'b0;
      r_owner   <= 1'b0;
      r_is_read <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= w_any;
      if (w_any) begin
        r_last    <= w_gnt1;
        r_hold    <= w_sel;
        r_owner   <= w_gnt1;
        r_is_read <= ~w_sel.we;
        r_err     <= w_err;
      end
    end
  end

  // the memory slices the previous load with whatever is on the pins now, so idle cycles replay the last access
  assign w_out    = w_any ? w_sel : r_hold;
  assign w_unused = w_out.we;

  assign bus.MEM_ADDR2  = ADDR_W'(w_out.addr);
  assign bus.MEM_DIN2   = w_out.din;
  assign bus.MEM_SIZE   = w_out.size;
  assign bus.MEM_SIGN   = w_out.sign;
  assign bus.MEM_WRITE2 = w_any &  w_sel.we & ~w_err;
  assign bus.MEM_READ2  = w_any & ~w_sel.we & ~w_err;

  assign bus.M0_GNT  = w_gnt0;
  assign bus.M1_GNT  = w_gnt1;
  assign bus.M0_RESP = r_valid & ~r_owner;
  assign bus.M1_RESP = r_valid &  r_owner;
  assign bus.M0_ERR  = r_valid & ~r_owner & r_err;
  assign bus.M1_ERR  = r_valid &  r_owner & r_err;

  assign bus.M0_RDATA = (r_valid & ~r_owner & r_is_read & ~r_err) ? bus.MEM_DOUT2 : 32'd0;
  assign bus.M1_RDATA = (r_valid &  r_owner & r_is_read & ~r_err) ? bus.MEM_DOUT2 : 32'd0;

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// tb/tb_otter_dmem_arbiter.sv - directed bench for otter_dmem_arbiter
module tb_otter_dmem_arbiter;

  logic CLK;
  logic RST_N;
  int   total;
  int   bad;

  otter_dmem_arbiter_if #(.ADDR_W(32)) bus ();
  otter_dmem_arbiter_if #(.ADDR_W(32)) fbus ();

  otter_dmem_arbiter #(.RR_EN(1'b1), .ADDR_W(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  otter_dmem_arbiter #(.RR_EN(1'b0), .ADDR_W(32)) dut_fp (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (fbus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // memory model: registered word, sliced with the live size/sign/address pins
  logic [31:0] mem [0:1023];
  logic [31:0] r_word;
  logic [31:0] dout;

  always @(posedge CLK) begin
    if (bus.MEM_WRITE2) begin
      logic [31:0] w;
      w = mem[bus.MEM_ADDR2[11:2]];
      case (bus.MEM_SIZE)
        2'd0:    w[8*bus.MEM_ADDR2[1:0] +: 8] = bus.MEM_DIN2[7:0];
        2'd1:    w[16*bus.MEM_ADDR2[1] +: 16] = bus.MEM_DIN2[15:0];
        default: w = bus.MEM_DIN2;
      endcase
      mem[bus.MEM_ADDR2[11:2]] <= w;
    end
    if (bus.MEM_READ2) r_word <= mem[bus.MEM_ADDR2[11:2]];
  end

  always_comb begin
    logic [31:0] sh;
    sh = r_word >> (8 * bus.MEM_ADDR2[1:0]);
    case (bus.MEM_SIZE)
      2'd0:    dout = bus.MEM_SIGN ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    dout = bus.MEM_SIGN ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: dout = r_word;
    endcase
  end

  assign bus.MEM_DOUT2  = dout;
  assign fbus.MEM_DOUT2 = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic m0(input logic req, input logic we, input logic [31:0] addr,
                    input logic [31:0] din, input logic [1:0] size, input logic sign);
    bus.M0_REQ = req; bus.M0_WE = we; bus.M0_ADDR = addr;
    bus.M0_DIN = din; bus.M0_SIZE = size; bus.M0_SIGN = sign;
  endtask

  task automatic m1(input logic req, input logic we, input logic [31:0] addr,
                    input logic [31:0] din, input logic [1:0] size, input logic sign);
    bus.M1_REQ = req; bus.M1_WE = we; bus.M1_ADDR = addr;
    bus.M1_DIN = din; bus.M1_SIZE = size; bus.M1_SIGN = sign;
  endtask

  task automatic fp(input logic r0, input logic r1);
    fbus.M0_REQ = r0; fbus.M0_WE = 1'b0; fbus.M0_ADDR = 32'h0; fbus.M0_DIN = 32'h0;
    fbus.M0_SIZE = 2'd2; fbus.M0_SIGN = 1'b0;
    fbus.M1_REQ = r1; fbus.M1_WE = 1'b0; fbus.M1_ADDR = 32'h4; fbus.M1_DIN = 32'h0;
    fbus.M1_SIZE = 2'd2; fbus.M1_SIGN = 1'b0;
  endtask

  // a waiting master must keep REQ and its fields until granted
  logic        w0_wait, w1_wait;
  logic [70:0] p0, p1;
  initial begin w0_wait = 1'b0; w1_wait = 1'b0; p0 = '0; p1 = '0; end
  always @(negedge CLK) begin
    #2;
    if (RST_N && w0_wait) begin
      total++;
      assert (bus.M0_REQ && p0 === {bus.M0_WE, bus.M0_ADDR, bus.M0_DIN, bus.M0_SIZE, bus.M0_SIGN, 3'b0})
        else begin bad++; $error("FAIL hold_m0: got %h want %h", {bus.M0_WE, bus.M0_ADDR}, p0[70:38]); end
    end
    if (RST_N && w1_wait) begin
      total++;
      assert (bus.M1_REQ && p1 === {bus.M1_WE, bus.M1_ADDR, bus.M1_DIN, bus.M1_SIZE, bus.M1_SIGN, 3'b0})
        else begin bad++; $error("FAIL hold_m1: got %h want %h", {bus.M1_WE, bus.M1_ADDR}, p1[70:38]); end
    end
    w0_wait = RST_N && bus.M0_REQ && !bus.M0_GNT;
    w1_wait = RST_N && bus.M1_REQ && !bus.M1_GNT;
    p0 = {bus.M0_WE, bus.M0_ADDR, bus.M0_DIN, bus.M0_SIZE, bus.M0_SIGN, 3'b0};
    p1 = {bus.M1_WE, bus.M1_ADDR, bus.M1_DIN, bus.M1_SIZE, bus.M1_SIGN, 3'b0};
  end

  initial begin
    total = 0;
    bad   = 0;
    r_word = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[32'h200 >> 2] = 32'h0000_000A;
    mem[32'h300 >> 2] = 32'h0000_000B;
    RST_N = 1'b0;
    m0(0, 0, 0, 0, 0, 0);
    m1(0, 0, 0, 0, 0, 0);
    fp(0, 0);

    // reset holds everything quiet even with requests pending
    @(negedge CLK);
    m0(1, 0, 32'h200, 0, 2, 0); m1(1, 1, 32'h300, 32'h1, 2, 0); fp(1, 1);
    #1;
    chk1("rst_gnt0", bus.M0_GNT, 1'b0);
    chk1("rst_gnt1", bus.M1_GNT, 1'b0);
    chk1("rst_read2", bus.MEM_READ2, 1'b0);
    chk1("rst_write2", bus.MEM_WRITE2, 1'b0);
    chk1("rst_resp0", bus.M0_RESP, 1'b0);
    chk1("rst_resp1", bus.M1_RESP, 1'b0);
    chk("rst_rdata0", bus.M0_RDATA, 32'd0);
    chk("rst_addr2", bus.MEM_ADDR2, 32'd0);
    chk1("rst_fp_gnt0", fbus.M0_GNT, 1'b0);

    @(negedge CLK);
    RST_N = 1'b1;
    m0(0, 0, 0, 0, 0, 0); m1(0, 0, 0, 0, 0, 0); fp(0, 0);
    #1;
    chk1("idle_gnt0", bus.M0_GNT, 1'b0);

    // round robin, both reading every cycle
    @(negedge CLK);
    m0(1, 0, 32'h200, 0, 2, 0); m1(1, 0, 32'h300, 0, 2, 0);
    #1;
    chk1("rr1_gnt0", bus.M0_GNT, 1'b1);
    chk1("rr1_gnt1", bus.M1_GNT, 1'b0);
    chk1("rr1_read2", bus.MEM_READ2, 1'b1);
    chk("rr1_addr2", bus.MEM_ADDR2, 32'h200);

    @(negedge CLK); #1;
    chk1("rr2_gnt1", bus.M1_GNT, 1'b1);
    chk1("rr2_read2", bus.MEM_READ2, 1'b1);
    chk("rr2_addr2", bus.MEM_ADDR2, 32'h300);
    chk1("rr2_resp0", bus.M0_RESP, 1'b1);
    chk1("rr2_resp1", bus.M1_RESP, 1'b0);
    chk("rr2_rdata0", bus.M0_RDATA, 32'hA);
    chk("rr2_rdata1", bus.M1_RDATA, 32'h0);

    @(negedge CLK); #1;
    chk1("rr3_gnt0", bus.M0_GNT, 1'b1);
    chk1("rr3_read2", bus.MEM_READ2, 1'b1);
    chk1("rr3_resp1", bus.M1_RESP, 1'b1);
    chk("rr3_rdata1", bus.M1_RDATA, 32'hB);
    chk("rr3_rdata0", bus.M0_RDATA, 32'h0);

    @(negedge CLK); #1;
    chk1("rr4_gnt1", bus.M1_GNT, 1'b1);
    chk1("rr4_read2", bus.MEM_READ2, 1'b1);
    chk("rr4_rdata0", bus.M0_RDATA, 32'hA);

    @(negedge CLK);
    m1(0, 0, 0, 0, 0, 0);
    #1;
    chk1("rr5_gnt0", bus.M0_GNT, 1'b1);
    chk("rr5_rdata1", bus.M1_RDATA, 32'hB);

    @(negedge CLK);
    m0(0, 0, 0, 0, 0, 0);
    #1;
    chk1("rr6_read2", bus.MEM_READ2, 1'b0);
    chk("rr6_rdata0", bus.M0_RDATA, 32'hA);

    // read, write, read from alternating masters
    @(negedge CLK);
    m0(1, 0, 32'h200, 0, 2, 0);
    #1;
    chk1("alt1_gnt0", bus.M0_GNT, 1'b1);

    @(negedge CLK);
    m0(0, 0, 0, 0, 0, 0); m1(1, 1, 32'h500, 32'h55, 2, 0);
    #1;
    chk1("alt2_write2", bus.MEM_WRITE2, 1'b1);
    chk("alt2_rdata0", bus.M0_RDATA, 32'hA);

    @(negedge CLK);
    m1(0, 0, 0, 0, 0, 0); m0(1, 0, 32'h500, 0, 2, 0);
    #1;
    chk1("alt3_gnt0", bus.M0_GNT, 1'b1);
    chk1("alt3_resp1", bus.M1_RESP, 1'b1);
    chk("alt3_rdata1", bus.M1_RDATA, 32'h0);

    @(negedge CLK);
    m0(0, 0, 0, 0, 0, 0);
    #1;
    chk("alt4_rdata0", bus.M0_RDATA, 32'h55);
    chk1("alt4_resp1", bus.M1_RESP, 1'b0);

    // store then load through M0
    @(negedge CLK);
    m0(1, 1, 32'h100, 32'hDEADBEEF, 2, 0);
    #1;
    chk1("sw_gnt0", bus.M0_GNT, 1'b1);
    chk1("sw_write2", bus.MEM_WRITE2, 1'b1);
    chk("sw_din2", bus.MEM_DIN2, 32'hDEADBEEF);

    @(negedge CLK);
    m0(1, 0, 32'h100, 0, 2, 0);
    #1;
    chk1("lw_read2", bus.MEM_READ2, 1'b1);
    chk1("sw_resp0", bus.M0_RESP, 1'b1);
    chk1("sw_err0", bus.M0_ERR, 1'b0);

    @(negedge CLK);
    m0(0, 0, 0, 0, 0, 0);
    #1;
    chk("lw_rdata0", bus.M0_RDATA, 32'hDEADBEEF);
    chk("lw_hold_addr2", bus.MEM_ADDR2, 32'h100);

    // misaligned and illegal-size accesses
    @(negedge CLK);
    m0(1, 0, 32'h101, 0, 1, 0);
    #1;
    chk1("lh_gnt0", bus.M0_GNT, 1'b1);
    chk1("lh_read2", bus.MEM_READ2, 1'b0);

    @(negedge CLK);
    m0(1, 1, 32'h102, 32'h12345678, 2, 0);
    #1;
    chk1("swm_write2", bus.MEM_WRITE2, 1'b0);
    chk1("lh_err0", bus.M0_ERR, 1'b1);
    chk("lh_rdata0", bus.M0_RDATA, 32'h0);

    @(negedge CLK);
    m0(0, 0, 0, 0, 0, 0); m1(1, 0, 32'h100, 0, 3, 0);
    #1;
    chk1("sz3_read2", bus.MEM_READ2, 1'b0);
    chk1("swm_err0", bus.M0_ERR, 1'b1);

    @(negedge CLK);
    m1(0, 0, 0, 0, 0, 0);
    #1;
    chk1("sz3_err1", bus.M1_ERR, 1'b1);
    chk("sz3_rdata1", bus.M1_RDATA, 32'h0);
    chk("mis_mem", mem[32'h100 >> 2], 32'hDEADBEEF);

    // byte load followed by an idle cycle
    @(negedge CLK);
    m0(1, 1, 32'h200, 32'h11223344, 2, 0);
    @(negedge CLK);
    m0(1, 0, 32'h203, 0, 0, 1);
    #1;
    chk1("lbu_read2", bus.MEM_READ2, 1'b1);
    @(negedge CLK);
    m0(0, 0, 0, 0, 0, 0);
    #1;
    chk("lbu_rdata0", bus.M0_RDATA, 32'h0000_0011);
    chk("lbu_size", bus.MEM_SIZE, 2'd0);

    // fixed priority instance
    @(negedge CLK);
    fp(1, 1);
    #1;
    chk1("fp1_gnt0", fbus.M0_GNT, 1'b1);
    @(negedge CLK); #1;
    chk1("fp2_gnt0", fbus.M0_GNT, 1'b1);
    chk1("fp2_gnt1", fbus.M1_GNT, 1'b0);
    @(negedge CLK); #1;
    chk1("fp3_gnt1", fbus.M1_GNT, 1'b0);
    @(negedge CLK);
    fp(0, 1);
    #1;
    chk1("fp4_gnt1", fbus.M1_GNT, 1'b1);
    @(negedge CLK);
    fp(0, 0);

    // reset with a read in flight
    @(negedge CLK);
    m0(1, 0, 32'h200, 0, 2, 0);
    #1;
    chk1("rf_gnt0", bus.M0_GNT, 1'b1);
    @(negedge CLK);
    RST_N = 1'b0;
    m0(0, 0, 0, 0, 0, 0);
    #1;
    chk1("rf_resp0", bus.M0_RESP, 1'b0);
    chk("rf_rdata0", bus.M0_RDATA, 32'h0);
    chk("rf_addr2", bus.MEM_ADDR2, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    m0(1, 0, 32'h200, 0, 2, 0); m1(1, 0, 32'h300, 0, 2, 0);
    #1;
    chk1("rr_post_gnt0", bus.M0_GNT, 1'b1);
    chk1("rr_post_gnt1", bus.M1_GNT, 1'b0);
    chk1("rf_noresp", bus.M0_RESP, 1'b0);
    @(negedge CLK);
    m0(0, 0, 0, 0, 0, 0);
    #1;
    chk1("post_gnt1", bus.M1_GNT, 1'b1);
    chk("post_rdata0", bus.M0_RDATA, 32'h1122_3344);
    @(negedge CLK);
    m1(0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rdata1", bus.M1_RDATA, 32'hB);

    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
